// File: rtl/rc_step_sequencer.sv
// Step-response run controller for an RC model: clear, drive a step, detect settling.
// Optional RC_SEQ_TIMEOUT_EN adds a timeout output that ends a run when the run counter saturates.
module rc_step_sequencer #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [WIDTH-1:0] v_step,
    input  logic        [WIDTH-1:0] v_tol,
    input  logic        [CNT_W-1:0] hold_cycles,
    input  logic signed [WIDTH-1:0] v_out,
    output logic signed [WIDTH-1:0] v_in,
    output logic                    model_ce,
    output logic                    model_clr,
    output logic                    busy,
    output logic                    done,
    output logic                    settled,
`ifdef RC_SEQ_TIMEOUT_EN
    output logic                    timeout,
`endif
    output logic        [CNT_W-1:0] settle_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_FINISH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] v_step_q;
    logic        [WIDTH-1:0] v_tol_q;
    logic        [CNT_W-1:0] hold_q;
    logic        [CNT_W-1:0] run_cnt_q;
    logic        [CNT_W-1:0] streak_q;
    logic        [CNT_W-1:0] settle_cnt_q;
    logic                    settled_q;
`ifdef RC_SEQ_TIMEOUT_EN
    logic                    timeout_q;
`endif

    logic        [WIDTH:0]   diff;
    logic        [WIDTH:0]   err;
    logic                    in_band;
    logic        [CNT_W-1:0] streak_inc;
    logic        [CNT_W-1:0] run_inc;
    logic                    hit;
    logic                    run_sat;
    logic                    accept;

    // Sign-extend before subtracting so |diff| always fits in WIDTH+1 bits.
    assign diff       = {v_out[WIDTH-1], v_out} - {v_step_q[WIDTH-1], v_step_q};
    assign err        = diff[WIDTH] ? (~diff + 1'b1) : diff;
    assign in_band    = (err <= {1'b0, v_tol_q});
    assign streak_inc = (streak_q == CNT_MAX) ? streak_q : streak_q + CNT_ONE;
    assign run_inc    = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;
    assign hit        = in_band && (streak_inc >= hold_q);
    assign run_sat    = (run_cnt_q == CNT_MAX);
    assign accept     = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort)        state_d = S_IDLE;
                else if (hit)     state_d = S_FINISH;
`ifdef RC_SEQ_TIMEOUT_EN
                else if (run_sat) state_d = S_FINISH;
`endif
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        v_in      = '0;
        model_ce  = 1'b0;
        model_clr = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                model_clr = 1'b1;
                busy      = 1'b1;
            end
            S_RUN: begin
                v_in     = v_step_q;
                model_ce = 1'b1;
                busy     = 1'b1;
            end
            S_FINISH: begin
                v_in = v_step_q;
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_step_q     <= '0;
            v_tol_q      <= '0;
            hold_q       <= '0;
            run_cnt_q    <= '0;
            streak_q     <= '0;
            settle_cnt_q <= '0;
            settled_q    <= 1'b0;
`ifdef RC_SEQ_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else if (accept) begin
            v_step_q     <= v_step;
            v_tol_q      <= v_tol;
            hold_q       <= (hold_cycles == '0) ? CNT_ONE : hold_cycles;
            run_cnt_q    <= '0;
            streak_q     <= '0;
            settle_cnt_q <= '0;
            settled_q    <= 1'b0;
`ifdef RC_SEQ_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else if (state_q == S_RUN) begin
            run_cnt_q <= run_inc;
            streak_q  <= in_band ? streak_inc : '0;
            // A zero streak means the previous cycle was out of band (or this is the first cycle).
            if (in_band && streak_q == '0) settle_cnt_q <= run_cnt_q;
            if (!abort) begin
                if (hit) settled_q <= 1'b1;
`ifdef RC_SEQ_TIMEOUT_EN
                else if (run_sat) timeout_q <= 1'b1;
`endif
            end
        end
    end

    assign settled       = settled_q;
    assign settle_cycles = settle_cnt_q;
`ifdef RC_SEQ_TIMEOUT_EN
    assign timeout       = timeout_q;
`endif

endmodule

// File: doc/rc_step_sequencer.md
RC_STEP_SEQUENCER -- requirements
Module: rc_step_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 18: fixed-point word width of v_in/v_out/v_step/v_tol.
REQ-002 SHALL have parameter CNT_W, default 16: width of cycle counters and hold_cycles.
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a step-response run (sampled in IDLE only).
REQ-006 SHALL have port abort, input, 1: terminate the current run.
REQ-007 SHALL have port v_step, input, WIDTH, signed: target step level, same fixed-point format as v_out.
REQ-008 SHALL have port v_tol, input, WIDTH, unsigned: settling tolerance band.
REQ-009 SHALL have port hold_cycles, input, CNT_W: consecutive in-band cycles required to declare settled.
REQ-010 SHALL have port v_out, input, WIDTH, signed: model output.
REQ-011 SHALL have port v_in, output, WIDTH, signed: model input drive.
REQ-012 SHALL have port model_ce, output, 1: model time-step enable.
REQ-013 SHALL have port model_clr, output, 1: active-high model state clear.
REQ-014 SHALL have ports busy, done, settled (outputs, 1 each) and settle_cycles (output, CNT_W).

Function
REQ-015 SHALL implement states IDLE, CLEAR, RUN, FINISH.
REQ-016 In IDLE with start=1, SHALL register v_step, v_tol and max(hold_cycles,1), then enter CLEAR on the next edge.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 CLEAR SHALL last exactly 1 cycle with model_clr=1, model_ce=0, v_in=0, then enter RUN.
REQ-019 In RUN, SHALL drive v_in=registered v_step and model_ce=1, and increment run counter each cycle, starting at 0 on the first RUN cycle.
REQ-020 SHALL compute err=|v_out - v_step_reg| in WIDTH+1 bits; in-band when err <= v_tol_reg.
REQ-021 The streak counter SHALL increment when in-band and clear to 0 when out-of-band; settle_cycles SHALL latch the run counter value on each out-of-band→in-band transition (0 if in-band on the first RUN cycle).
REQ-022 When the streak counter reaches hold_reg, SHALL enter FINISH with settled=1.
REQ-023 FINISH SHALL last 1 cycle: done=1 pulse, model_ce=0, v_in held at step; then enter IDLE.
REQ-024 settled and settle_cycles SHALL hold their values until the next start is accepted, then clear.
REQ-025 The run and streak counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 abort=1 in CLEAR or RUN SHALL enter IDLE on the next edge with settled=0 and no done pulse; abort SHALL have priority over settle detection in the same cycle.
REQ-027 busy SHALL be 1 in CLEAR, RUN and FINISH, and 0 in IDLE.
REQ-028 In IDLE, SHALL drive v_in=0, model_ce=0, model_clr=0.

Reset
REQ-029 On rst=0, SHALL immediately force IDLE; v_in=0, model_ce=0, model_clr=0, busy=0, done=0, settled=0, settle_cycles=0, all internal registers 0.
REQ-030 Reset asserted mid-run SHALL discard the run with no done pulse.

Configuration
REQ-031 With macro RC_SEQ_TIMEOUT_EN defined, SHALL add output timeout (1 bit, reset 0) and enter FINISH with settled=0, timeout=1 when the run counter saturates in RUN.
REQ-032 timeout SHALL clear on the next accepted start.
REQ-033 Without RC_SEQ_TIMEOUT_EN, the timeout port SHALL not exist and RUN SHALL continue after saturation until settled or abort.

Verification
REQ-034 v_step=1.0, v_tol=0.01, hold=4, v_out ramps into band at RUN cycle 20 and stays -> settled=1, settle_cycles=20, done pulse at cycle 24 of RUN+1.
REQ-035 v_out enters band at cycle 10, leaves at 12, re-enters at 15, hold=4 -> settle_cycles=15, done after 4 in-band cycles.
REQ-036 abort asserted on the same cycle the streak reaches hold -> IDLE next cycle, settled=0, no done.
REQ-037 hold_cycles=0, v_out in band on the first RUN cycle -> settled after 1 cycle, settle_cycles=0.
REQ-038 rst pulled low mid-RUN, then start issued while busy -> outputs immediately at reset values; start while busy ignored, with no re-capture of v_step.
REQ-039 With RC_SEQ_TIMEOUT_EN, CNT_W=4, v_out never in band -> timeout=1, settled=0, done pulse after the run counter reaches 15.
